shot_table: RTL and testbench
=============================

# shot_table

Owns the player-shot entity slots consumed by the collision stage. Accepts fire requests from the ship logic and answers the collision stage's `delete_shot`/`shot_address` requests with an acknowledge. On each frame tick it advances every live shot and retires shots that leave the 320x240 playfield. It drives the packed `shots` array read by collision detection and the renderer.

## Interface
- `MAX_SHOTS`, 3: number of shot slots (1..16)
- `ENTITY_SIZE`, 34: packed entity width
- `SHOT_SPEED`, 4: pixels moved per axis per frame
- `SHOT_LIFETIME`, 40: frames before expiry (only with `SHOT_LIFETIME_EN`)
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `fire`  in  1  single-cycle spawn request
- `fire_x`, `fire_y`  in  10 each  spawn position
- `fire_heading`  in  3  direction: 0 N, 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW
- `fire_ack`  out  1  pulse: shot allocated
- `fire_drop`  out  1  pulse: request discarded
- `delete_shot`  in  1  delete request from collision stage
- `shot_address`  in  10  slot to delete
- `delete_ack`  out  1  pulse: delete request consumed
- `frame_tick`  in  1  one pulse per video frame
- `busy`  out  1  high while the move sweep runs
- `frame_overrun`  out  1  pulse: tick arrived while busy
- `shots`  out  MAX_SHOTS x ENTITY_SIZE  slot contents
- `active_count`  out  $clog2(MAX_SHOTS+1)  live slot count

## Operation
- Entity layout: [33] active, [32:30] heading, [29:26] zero, [25:16] y, [15:6] x, [5:0] kind (2 = shot).
- States: IDLE, MOVE. IDLE + `frame_tick` -> MOVE, idx = 0. MOVE processes slot idx each cycle. After idx = MAX_SHOTS-1, return to IDLE.
- Move: dx,dy ∈ {-SPEED,0,+SPEED} per heading (diagonals move SPEED on both axes). Compute in 11-bit signed. Slot is cleared (all bits 0) if new x < 0 or > 319, or new y < 0 or > 239. Otherwise x/y are updated.
- Fire in IDLE: write the lowest-index inactive slot (free map taken before any same-cycle delete). If no slot is free, pulse `fire_drop`.
- Fire in MOVE: latched into a one-deep pending register and serviced on the first IDLE cycle. A second fire while one is pending pulses `fire_drop`.
- Delete: accepted in every state. Requests are level-sampled and each sampled cycle is acked. An inactive slot or `shot_address` >= MAX_SHOTS produces no change but is still acked.
- Same-slot conflicts: delete beats move. Delete beats a fire into that slot only via the pre-delete free map, so a freed slot becomes allocatable the next cycle.
- `frame_tick` while busy: ignored; `frame_overrun` pulses.

## Timing
- All outputs are registered.
- Reset value of every output and slot is 0; state IDLE; pending fire cleared.
- Reset mid-MOVE aborts the sweep and clears everything.
- Fire/delete take effect at the sampling edge. `shots`, `fire_ack`/`fire_drop`/`delete_ack` and `active_count` are visible the following cycle.
- Sweep latency is MAX_SHOTS cycles. `busy` is high from the cycle after the tick through the last slot.
- A pending fire is acked 1 cycle after `busy` falls.

## Configuration
- `SHOT_LIFETIME_EN` defined: each slot has a 6-bit age counter. It is reset on spawn and incremented per swept frame. When age reaches SHOT_LIFETIME, the slot is cleared during the sweep.
- `SHOT_LIFETIME_EN` undefined: no counters; shots live until deleted or out of bounds.

## Structure
- Shared package `asteroids_pkg` holds:
  - ENTITY_SIZE and field bit positions
  - SCREEN_W = 320, SCREEN_H = 240
  - KIND_SHOT = 2
  - heading enum
  - state enum
- Sub-module `shot_step`: combinational next-position plus bounds flag for a given heading, x, y and SPEED.

## Test plan
- Fire at (100,100) heading E, then one tick -> slot0 x = 104, y = 100, active; `fire_ack` one cycle after fire.
- Fire four times with MAX_SHOTS = 3 -> three acks, then `fire_drop` on the fourth; `active_count` = 3.
- Shot at (318,50) heading E, tick -> slot cleared, `active_count` decrements.
- Delete slot 1 at the same cycle the sweep moves slot 1 -> slot 1 inactive after the sweep; `delete_ack` pulses once.
- Fire while busy -> serviced after the sweep; a second fire while busy -> `fire_drop`. Tick while busy -> `frame_overrun`.
- `reset_n` low mid-sweep -> all slots 0, `busy` 0 and all pulses 0 while asserted.

Source files
------------

// File: rtl/asteroids_pkg.sv
// asteroids_pkg
// Shared definitions for the entity tables: the packed entity layout, the
// playfield size, the shot kind code, the heading and sweep-state encodings,
// and a helper that packs a freshly spawned shot.
// Ports: none (package).

package asteroids_pkg;

    // Entity layout:
    // [33] active, [32:30] heading, [29:26] zero, [25:16] y, [15:6] x, [5:0] kind
    localparam int ENTITY_WIDTH = 34;
    localparam int BIT_ACTIVE   = 33;
    localparam int Y_HI         = 25;
    localparam int Y_LO         = 16;
    localparam int X_HI         = 15;
    localparam int X_LO         = 6;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam logic [5:0] KIND_SHOT = 6'd2;

    typedef enum logic [2:0] {
        HD_N  = 3'd0,
        HD_NE = 3'd1,
        HD_E  = 3'd2,
        HD_SE = 3'd3,
        HD_S  = 3'd4,
        HD_SW = 3'd5,
        HD_W  = 3'd6,
        HD_NW = 3'd7
    } heading_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_e;

    function automatic logic [ENTITY_WIDTH-1:0] make_shot(input logic [2:0] hd,
                                                          input logic [9:0] x,
                                                          input logic [9:0] y);
        return {1'b1, hd, 4'b0000, y, x, KIND_SHOT};
    endfunction

endpackage

// File: rtl/shot_step.sv
// shot_step
// Combinational one-frame step of a shot: applies the per-heading velocity
// (SPEED pixels on each moving axis, diagonals on both) in 11-bit signed
// arithmetic and flags a result that falls outside the playfield.
// Ports:
//   heading     in  3   direction, 0 = N then clockwise to 7 = NW
//   x, y        in  10  current position
//   x_next      out 10  stepped x (low bits; only meaningful if !off_screen)
//   y_next      out 10  stepped y
//   off_screen  out 1   stepped position is outside 0..319 x 0..239

module shot_step
    import asteroids_pkg::*;
#(
    parameter int SPEED = 4
) (
    input  logic [2:0] heading,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [9:0] x_next,
    output logic [9:0] y_next,
    output logic       off_screen
);

    localparam logic signed [10:0] STEP  = 11'(SPEED);
    localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] nx;
    logic signed [10:0] ny;

    always_comb begin
        dx = '0;
        dy = '0;
        // screen y grows downward, so north is a negative y step
        case (heading_e'(heading))
            HD_N:  dy = -STEP;
            HD_NE: begin dx =  STEP; dy = -STEP; end
            HD_E:  dx =  STEP;
            HD_SE: begin dx =  STEP; dy =  STEP; end
            HD_S:  dy =  STEP;
            HD_SW: begin dx = -STEP; dy =  STEP; end
            HD_W:  dx = -STEP;
            HD_NW: begin dx = -STEP; dy = -STEP; end
            default: ;
        endcase
        nx = $signed({1'b0, x}) + dx;
        ny = $signed({1'b0, y}) + dy;
        off_screen = (nx < 11'sd0) || (nx > X_MAX) || (ny < 11'sd0) || (ny > Y_MAX);
        x_next = nx[9:0];
        y_next = ny[9:0];
    end

endmodule

// File: rtl/shot_table.sv
// shot_table
// Owns the player-shot slots. Allocates fire requests into the lowest free
// slot, services collision-stage deletes, and on each frame tick sweeps one
// slot per cycle, moving live shots and retiring those leaving the playfield.
// Optional build macro: SHOT_LIFETIME_EN adds a 6-bit per-slot age counter
// that retires a shot once it has been swept SHOT_LIFETIME times.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   fire, fire_x, fire_y,
//   fire_heading                    spawn request and its position/direction
//   fire_ack / fire_drop       out  shot allocated / request discarded (pulses)
//   delete_shot, shot_address       delete request from collision stage
//   delete_ack                 out  delete request consumed (pulse)
//   frame_tick                      starts a move sweep
//   busy                       out  sweep in progress
//   frame_overrun              out  tick arrived while sweeping (pulse)
//   shots                      out  packed slot contents
//   active_count               out  number of live slots
//
// state   | meaning
// IDLE    | waiting for frame_tick; fires (new or pending) allocate here
// MOVE    | sweeping slot idx_q; fires wait in the one-deep pending register

module shot_table #(
    parameter int MAX_SHOTS     = 3,
    parameter int ENTITY_SIZE   = asteroids_pkg::ENTITY_WIDTH,
    parameter int SHOT_SPEED    = 4,
    parameter int SHOT_LIFETIME = 40
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  fire,
    input  logic [9:0]                            fire_x,
    input  logic [9:0]                            fire_y,
    input  logic [2:0]                            fire_heading,
    output logic                                  fire_ack,
    output logic                                  fire_drop,
    input  logic                                  delete_shot,
    input  logic [9:0]                            shot_address,
    output logic                                  delete_ack,
    input  logic                                  frame_tick,
    output logic                                  busy,
    output logic                                  frame_overrun,
    output logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0] shots,
    output logic [$clog2(MAX_SHOTS+1)-1:0]        active_count
);

    import asteroids_pkg::*;

    localparam int IDX_W = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
    localparam int CNT_W = $clog2(MAX_SHOTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SHOTS - 1);

    state_e                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic                                  pend_q, pend_d;
    logic [9:0]                            pend_x_q, pend_x_d;
    logic [9:0]                            pend_y_q, pend_y_d;
    logic [2:0]                            pend_hd_q, pend_hd_d;
    logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0] shots_d;
    logic [CNT_W-1:0]                      count_d;
    logic                                  ack_d, drop_d, overrun_d;
    logic                                  spawn, free_found;
    logic [IDX_W-1:0]                      free_idx;
    logic [MAX_SHOTS-1:0]                  spawn_hit, move_hit;
    logic [ENTITY_SIZE-1:0]                spawn_ent, cur_ent, moved_ent;
    logic [9:0]                            step_x, step_y;
    logic                                  step_off;
    logic                                  expired;

    assign cur_ent = shots[idx_q];

    shot_step #(
        .SPEED (SHOT_SPEED)
    ) u_step (
        .heading    (cur_ent[BIT_ACTIVE-1:BIT_ACTIVE-3]),
        .x          (cur_ent[X_HI:X_LO]),
        .y          (cur_ent[Y_HI:Y_LO]),
        .x_next     (step_x),
        .y_next     (step_y),
        .off_screen (step_off)
    );

`ifdef SHOT_LIFETIME_EN
    logic [MAX_SHOTS-1:0][5:0] age_q, age_d;
    logic [5:0]                age_next;

    always_comb begin
        age_next = age_q[idx_q] + 6'd1;
        expired  = (age_next >= 6'(SHOT_LIFETIME));
        age_d    = age_q;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            if (move_hit[i])  age_d[i] = age_next;
            if (spawn_hit[i]) age_d[i] = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) age_q <= '0;
        else          age_q <= age_d;
    end
`else
    logic [5:0] unused_lifetime;
    assign unused_lifetime = 6'(SHOT_LIFETIME);
    assign expired = 1'b0;
`endif

    always_comb begin
        // lowest free slot, judged on the table as it stood before this cycle
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
            if (!shots[i][BIT_ACTIVE]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        spawn     = (state_q == ST_IDLE) && (pend_q || fire);
        spawn_ent = pend_q ? make_shot(pend_hd_q, pend_x_q, pend_y_q)
                           : make_shot(fire_heading, fire_x, fire_y);

        moved_ent              = cur_ent;
        moved_ent[Y_HI:Y_LO]   = step_y;
        moved_ent[X_HI:X_LO]   = step_x;
        if (step_off || expired) moved_ent = '0;

        // the pending shot goes out first; a fire arriving in that same cycle
        // takes its place in the pending register
        pend_d    = pend_q;
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        pend_hd_d = pend_hd_q;
        drop_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            pend_d = pend_q && fire;
            if (pend_q && fire) begin
                pend_x_d  = fire_x;
                pend_y_d  = fire_y;
                pend_hd_d = fire_heading;
            end
        end else if (fire) begin
            if (pend_q) begin
                drop_d = 1'b1;
            end else begin
                pend_d    = 1'b1;
                pend_x_d  = fire_x;
                pend_y_d  = fire_y;
                pend_hd_d = fire_heading;
            end
        end
        ack_d = spawn && free_found;
        if (spawn && !free_found) drop_d = 1'b1;

        // delete is applied last so it wins over a move of the same slot; it
        // only touches live slots, which a spawn never targets
        move_hit  = '0;
        spawn_hit = '0;
        shots_d   = shots;
        count_d   = '0;
        for (int i = 0; i < MAX_SHOTS; i++) begin
            move_hit[i]  = (state_q == ST_MOVE) && (idx_q == IDX_W'(i)) && shots[i][BIT_ACTIVE];
            spawn_hit[i] = spawn && free_found && (free_idx == IDX_W'(i));
            if (move_hit[i])  shots_d[i] = moved_ent;
            if (spawn_hit[i]) shots_d[i] = spawn_ent;
            if (delete_shot && (shot_address == 10'(i)) && shots[i][BIT_ACTIVE])
                shots_d[i] = '0;
            count_d = count_d + CNT_W'(shots_d[i][BIT_ACTIVE]);
        end

        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_d = ST_MOVE;
                    idx_d   = '0;
                end
            end
            ST_MOVE: begin
                overrun_d = frame_tick;
                if (idx_q == LAST_IDX) state_d = ST_IDLE;
                else                   idx_d   = idx_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pend_q        <= 1'b0;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            pend_hd_q     <= '0;
            shots         <= '0;
            active_count  <= '0;
            fire_ack      <= 1'b0;
            fire_drop     <= 1'b0;
            delete_ack    <= 1'b0;
            busy          <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            pend_hd_q     <= pend_hd_d;
            shots         <= shots_d;
            active_count  <= count_d;
            fire_ack      <= ack_d;
            fire_drop     <= drop_d;
            delete_ack    <= delete_shot;
            busy          <= (state_d == ST_MOVE);
            frame_overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_shot_table.sv
`timescale 1ns/1ps
module tb_shot_table;

    localparam int MAX   = 3;
    localparam int SPEED = 4;
    localparam int LIFE  = 40;
`ifdef SHOT_LIFETIME_EN
    localparam bit LIFE_ON = 1'b1;
`else
    localparam bit LIFE_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             fire = 1'b0;
    logic [9:0]       fire_x = '0;
    logic [9:0]       fire_y = '0;
    logic [2:0]       fire_heading = '0;
    logic             delete_shot = 1'b0;
    logic [9:0]       shot_address = '0;
    logic             frame_tick = 1'b0;
    logic             fire_ack, fire_drop, delete_ack, busy, frame_overrun;
    logic [MAX-1:0][33:0] shots;
    logic [1:0]       active_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    shot_table #(
        .MAX_SHOTS     (MAX),
        .ENTITY_SIZE   (34),
        .SHOT_SPEED    (SPEED),
        .SHOT_LIFETIME (LIFE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fire          (fire),
        .fire_x        (fire_x),
        .fire_y        (fire_y),
        .fire_heading  (fire_heading),
        .fire_ack      (fire_ack),
        .fire_drop     (fire_drop),
        .delete_shot   (delete_shot),
        .shot_address  (shot_address),
        .delete_ack    (delete_ack),
        .frame_tick    (frame_tick),
        .busy          (busy),
        .frame_overrun (frame_overrun),
        .shots         (shots),
        .active_count  (active_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_act[MAX];
    int m_hd[MAX];
    int m_x[MAX];
    int m_y[MAX];
    int m_age[MAX];
    int m_sweep = -1;          // -1 idle, else the slot moved at the next edge
    bit m_pend = 1'b0;
    int p_x, p_y, p_hd;
    bit e_ack, e_drop, e_dack, e_ovr, e_busy;
    int dx_tab[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dy_tab[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int pre[MAX];
    int slot, nx, ny, nxt, sx, sy, sh;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX; i++) begin
                m_act[i] = 0; m_hd[i] = 0; m_x[i] = 0; m_y[i] = 0; m_age[i] = 0;
            end
            m_sweep = -1; m_pend = 1'b0;
            e_ack = 0; e_drop = 0; e_dack = 0; e_ovr = 0; e_busy = 0;
        end else begin
            for (int i = 0; i < MAX; i++) pre[i] = m_act[i];
            e_ack = 0; e_drop = 0; e_ovr = 0; e_dack = delete_shot;
            nxt = m_sweep;
            if (m_sweep < 0) begin
                if (m_pend || fire) begin
                    if (m_pend) begin sx = p_x; sy = p_y; sh = p_hd; end
                    else begin sx = int'(fire_x); sy = int'(fire_y); sh = int'(fire_heading); end
                    slot = -1;
                    for (int i = MAX - 1; i >= 0; i--) if (pre[i] == 0) slot = i;
                    if (slot >= 0) begin
                        m_act[slot] = 1; m_x[slot] = sx; m_y[slot] = sy;
                        m_hd[slot] = sh; m_age[slot] = 0; e_ack = 1;
                    end else e_drop = 1;
                end
                if (m_pend && fire) begin
                    p_x = int'(fire_x); p_y = int'(fire_y); p_hd = int'(fire_heading);
                end else m_pend = 1'b0;
                if (frame_tick) nxt = 0;
            end else begin
                slot = m_sweep;
                if (m_act[slot] != 0) begin
                    nx = m_x[slot] + dx_tab[m_hd[slot]] * SPEED;
                    ny = m_y[slot] + dy_tab[m_hd[slot]] * SPEED;
                    m_age[slot]++;
                    if (nx < 0 || nx > 319 || ny < 0 || ny > 239 || (LIFE_ON && m_age[slot] >= LIFE))
                        m_act[slot] = 0;
                    else begin
                        m_x[slot] = nx; m_y[slot] = ny;
                    end
                end
                if (fire) begin
                    if (m_pend) e_drop = 1;
                    else begin
                        m_pend = 1'b1;
                        p_x = int'(fire_x); p_y = int'(fire_y); p_hd = int'(fire_heading);
                    end
                end
                e_ovr = frame_tick;
                nxt = (m_sweep == MAX - 1) ? -1 : m_sweep + 1;
            end
            if (delete_shot && shot_address < MAX && pre[shot_address] != 0)
                m_act[shot_address] = 0;
            m_sweep = nxt;
            e_busy = (m_sweep >= 0);
        end
    end

    function automatic logic [33:0] ent(input int i);
        if (m_act[i] == 0) return '0;
        return {1'b1, 3'(m_hd[i]), 4'd0, 10'(m_y[i]), 10'(m_x[i]), 6'd2};
    endfunction

    function automatic int live_count();
        int n = 0;
        for (int i = 0; i < MAX; i++) n += m_act[i];
        return n;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fire_ack", fire_ack, e_ack);
            chk("fire_drop", fire_drop, e_drop);
            chk("delete_ack", delete_ack, e_dack);
            chk("frame_overrun", frame_overrun, e_ovr);
            chk("busy", busy, e_busy);
            chk("active_count", active_count, live_count());
            for (int i = 0; i < MAX; i++) chk($sformatf("slot%0d", i), shots[i], ent(i));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fire = 0; delete_shot = 0; frame_tick = 0;
        reset_n = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
    endtask

    task automatic set_fire(input int x, input int y, input int h);
        fire = 1'b1; fire_x = 10'(x); fire_y = 10'(y); fire_heading = 3'(h);
    endtask

    initial begin
        cyc();
        chk_en = 1'b1;
        do_reset();
        chk("rst_count", active_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slot0", shots[0], 0);

        // spawn and move east
        set_fire(100, 100, 2); cyc(); fire = 0;
        chk("first_ack", fire_ack, 1);
        chk("spawn_word", shots[0], {1'b1, 3'd2, 4'd0, 10'd100, 10'd100, 6'd2});
        frame_tick = 1; cyc(); frame_tick = 0;
        chk("busy_after_tick", busy, 1);
        cyc();
        chk("moved_east", shots[0], {1'b1, 3'd2, 4'd0, 10'd100, 10'd104, 6'd2});
        cyc(); cyc();
        chk("busy_fall", busy, 0);

        // four fires into three slots
        do_reset();
        set_fire(10, 10, 4);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("burst_ack", fire_ack, (k < 3));
            chk("burst_drop", fire_drop, (k == 3));
        end
        fire = 0;
        chk("burst_count", active_count, 3);

        // leaving the right edge
        do_reset();
        set_fire(318, 50, 2); cyc(); fire = 0;
        chk("edge_count1", active_count, 1);
        frame_tick = 1; cyc(); frame_tick = 0; cyc();
        chk("edge_cleared", shots[0], 0);
        chk("edge_count0", active_count, 0);

        // delete slot 1 on the cycle the sweep moves it
        do_reset();
        set_fire(50, 100, 0); cyc();
        set_fire(60, 100, 0); cyc(); fire = 0;
        frame_tick = 1; cyc(); frame_tick = 0;
        cyc();
        delete_shot = 1; shot_address = 10'd1; cyc(); delete_shot = 0;
        chk("del_ack", delete_ack, 1);
        chk("del_slot1", shots[1], 0);
        cyc();
        chk("del_ack_once", delete_ack, 0);
        chk("del_slot0_moved", shots[0], {1'b1, 3'd0, 4'd0, 10'd96, 10'd50, 6'd2});

        // fire and tick while busy
        do_reset();
        frame_tick = 1; cyc();
        set_fire(20, 20, 3); cyc(); frame_tick = 0;
        chk("overrun", frame_overrun, 1);
        chk("pending_no_ack", fire_ack, 0);
        set_fire(30, 30, 3); cyc(); fire = 0;
        chk("second_fire_drop", fire_drop, 1);
        cyc();
        chk("busy_done", busy, 0);
        cyc();
        chk("pending_ack", fire_ack, 1);
        chk("pending_word", shots[0], {1'b1, 3'd3, 4'd0, 10'd20, 10'd20, 6'd2});

        // reset in the middle of a sweep
        set_fire(200, 200, 6); cyc(); fire = 0;
        frame_tick = 1; cyc(); frame_tick = 0; cyc();
        delete_shot = 1; shot_address = 10'd0;
        reset_n = 1'b0; #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_slots", shots, 0);
        chk("rst_mid_count", active_count, 0);
        cyc();
        chk("rst_mid_dack", delete_ack, 0);
        chk("rst_mid_ack", fire_ack, 0);
        delete_shot = 0;
        reset_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            fire         = ($urandom_range(0, 3) == 0);
            fire_x       = 10'($urandom_range(0, 335));
            fire_y       = 10'($urandom_range(0, 255));
            fire_heading = 3'($urandom_range(0, 7));
            delete_shot  = ($urandom_range(0, 5) == 0);
            shot_address = 10'($urandom_range(0, 4));
            frame_tick   = ($urandom_range(0, 4) == 0);
            reset_n      = ($urandom_range(0, 599) != 0);
            cyc();
        end
        fire = 0; delete_shot = 0; frame_tick = 0; reset_n = 1'b1;
        cyc(); cyc();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
